pipeline_regs: RTL and testbench

PIPELINE_REGS -- requirements
Module: pipeline_regs

---
 rtl/pipeline_regs_if.sv | 83 ++++++++
 rtl/pipeline_regs.sv | 139 +++++++++++++
 tb/tb_pipeline_regs.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/pipeline_regs_if.sv
// Signal bundle for the IF/ID, ID/EX and EX/MEM pipeline registers.
// The slave modport is the register block; the master modport is the surrounding datapath.
interface pipeline_regs_if #(
  parameter int DATA_W = 32
);
  logic              ifid_en;
  logic [DATA_W-1:0] f_instruction;
  logic [DATA_W-1:0] f_pc_plus4;
  logic [DATA_W-1:0] d_instruction;
  logic [DATA_W-1:0] d_pc_plus4;

  logic              idex_en;
  logic [DATA_W-1:0] d_pc_plus4_in;
  logic [DATA_W-1:0] d_sign_ext;
  logic [DATA_W-1:0] d_read_data1;
  logic [DATA_W-1:0] d_read_data2;
  logic [4:0]        d_rs;
  logic [4:0]        d_rt;
  logic [4:0]        d_rd;
  logic [1:0]        d_alu_op;
  logic [5:0]        d_funct;
  logic              d_reg_write;
  logic              d_mem_to_reg;
  logic              d_branch;
  logic              d_mem_read;
  logic              d_mem_write;
  logic              d_reg_dst;
  logic              d_alu_src;
  logic              d_zero;

  logic [DATA_W-1:0] x_pc_plus4;
  logic [DATA_W-1:0] x_sign_ext;
  logic [DATA_W-1:0] x_read_data1;
  logic [DATA_W-1:0] x_read_data2;
  logic [4:0]        x_rs;
  logic [4:0]        x_rt;
  logic [4:0]        x_rd;
  logic [5:0]        x_funct;
  logic              x_zero;
  logic [1:0]        x_wb;
  logic [2:0]        x_m;
  logic [3:0]        x_ex;

  logic [DATA_W-1:0] x_alu_result;
  logic [DATA_W-1:0] x_write_data;
  logic [4:0]        x_write_reg;
  logic [1:0]        x_wb_in;
  logic [2:0]        x_m_in;
  logic              x_zero_in;

  logic [DATA_W-1:0] m_alu_result;
  logic [DATA_W-1:0] m_write_data;
  logic [4:0]        m_write_reg;
  logic [1:0]        m_wb;
  logic [2:0]        m_m;
  logic              m_zero;

  modport master (
    output ifid_en, f_instruction, f_pc_plus4,
    input  d_instruction, d_pc_plus4,
    output idex_en, d_pc_plus4_in, d_sign_ext, d_read_data1, d_read_data2,
    output d_rs, d_rt, d_rd, d_alu_op, d_funct,
    output d_reg_write, d_mem_to_reg, d_branch, d_mem_read, d_mem_write,
    output d_reg_dst, d_alu_src, d_zero,
    input  x_pc_plus4, x_sign_ext, x_read_data1, x_read_data2,
    input  x_rs, x_rt, x_rd, x_funct, x_zero, x_wb, x_m, x_ex,
    output x_alu_result, x_write_data, x_write_reg, x_wb_in, x_m_in, x_zero_in,
    input  m_alu_result, m_write_data, m_write_reg, m_wb, m_m, m_zero
  );

  modport slave (
    input  ifid_en, f_instruction, f_pc_plus4,
    output d_instruction, d_pc_plus4,
    input  idex_en, d_pc_plus4_in, d_sign_ext, d_read_data1, d_read_data2,
    input  d_rs, d_rt, d_rd, d_alu_op, d_funct,
    input  d_reg_write, d_mem_to_reg, d_branch, d_mem_read, d_mem_write,
    input  d_reg_dst, d_alu_src, d_zero,
    output x_pc_plus4, x_sign_ext, x_read_data1, x_read_data2,
    output x_rs, x_rt, x_rd, x_funct, x_zero, x_wb, x_m, x_ex,
    input  x_alu_result, x_write_data, x_write_reg, x_wb_in, x_m_in, x_zero_in,
    output m_alu_result, m_write_data, m_write_reg, m_wb, m_m, m_zero
  );
endinterface

// File: rtl/pipeline_regs.sv
// IF/ID, ID/EX and EX/MEM pipeline registers of a 5-stage MIPS-style core.
// IF/ID can stall, ID/EX can inject a control bubble, EX/MEM always advances.
module pipeline_regs #(
  parameter int DATA_W = 32
) (
  input logic           clk,
  input logic           reset,
  pipeline_regs_if.slave bus
);

  function automatic logic [1:0] pack_wb(input logic mem_to_reg, input logic reg_write);
    return {mem_to_reg, reg_write};
  endfunction

  function automatic logic [2:0] pack_m(input logic branch, input logic mem_read,
                                        input logic mem_write);
    return {branch, mem_read, mem_write};
  endfunction

  function automatic logic [3:0] pack_ex(input logic reg_dst, input logic [1:0] alu_op,
                                         input logic alu_src);
    return {reg_dst, alu_op, alu_src};
  endfunction

  logic [DATA_W-1:0] instr_p0;
  logic [DATA_W-1:0] pc4_p0;

  logic [DATA_W-1:0] pc4_p1;
  logic [DATA_W-1:0] sign_ext_p1;
  logic [DATA_W-1:0] rd1_p1;
  logic [DATA_W-1:0] rd2_p1;
  logic [4:0]        rs_p1;
  logic [4:0]        rt_p1;
  logic [4:0]        rd_p1;
  logic [5:0]        funct_p1;
  logic              zero_p1;
  logic [1:0]        wb_p1;
  logic [2:0]        m_p1;
  logic [3:0]        ex_p1;

  logic [DATA_W-1:0] alu_result_p2;
  logic [DATA_W-1:0] write_data_p2;
  logic [4:0]        write_reg_p2;
  logic [1:0]        wb_p2;
  logic [2:0]        m_p2;
  logic              zero_p2;

  // IF/ID: load on ifid_en, hold otherwise
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr_p0 <= '0;
      pc4_p0   <= '0;
    end else if (bus.ifid_en) begin
      instr_p0 <= bus.f_instruction;
      pc4_p0   <= bus.f_pc_plus4;
    end
  end

  // ID/EX: data always captured; a bubble only zeroes the control fields
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc4_p1      <= '0;
      sign_ext_p1 <= '0;
      rd1_p1      <= '0;
      rd2_p1      <= '0;
      rs_p1       <= '0;
      rt_p1       <= '0;
      rd_p1       <= '0;
      funct_p1    <= '0;
      zero_p1     <= 1'b0;
      wb_p1       <= '0;
      m_p1        <= '0;
      ex_p1       <= '0;
    end else begin
      pc4_p1      <= bus.d_pc_plus4_in;
      sign_ext_p1 <= bus.d_sign_ext;
      rd1_p1      <= bus.d_read_data1;
      rd2_p1      <= bus.d_read_data2;
      rs_p1       <= bus.d_rs;
      rt_p1       <= bus.d_rt;
      rd_p1       <= bus.d_rd;
      funct_p1    <= bus.d_funct;
      if (bus.idex_en) begin
        zero_p1 <= bus.d_zero;
        wb_p1   <= pack_wb(bus.d_mem_to_reg, bus.d_reg_write);
        m_p1    <= pack_m(bus.d_branch, bus.d_mem_read, bus.d_mem_write);
        ex_p1   <= pack_ex(bus.d_reg_dst, bus.d_alu_op, bus.d_alu_src);
      end else begin
        zero_p1 <= 1'b0;
        wb_p1   <= '0;
        m_p1    <= '0;
        ex_p1   <= '0;
      end
    end
  end

  // EX/MEM: free-running, captures every edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alu_result_p2 <= '0;
      write_data_p2 <= '0;
      write_reg_p2  <= '0;
      wb_p2         <= '0;
      m_p2          <= '0;
      zero_p2       <= 1'b0;
    end else begin
      alu_result_p2 <= bus.x_alu_result;
      write_data_p2 <= bus.x_write_data;
      write_reg_p2  <= bus.x_write_reg;
      wb_p2         <= bus.x_wb_in;
      m_p2          <= bus.x_m_in;
      zero_p2       <= bus.x_zero_in;
    end
  end

  assign bus.d_instruction = instr_p0;
  assign bus.d_pc_plus4    = pc4_p0;

  assign bus.x_pc_plus4    = pc4_p1;
  assign bus.x_sign_ext    = sign_ext_p1;
  assign bus.x_read_data1  = rd1_p1;
  assign bus.x_read_data2  = rd2_p1;
  assign bus.x_rs          = rs_p1;
  assign bus.x_rt          = rt_p1;
  assign bus.x_rd          = rd_p1;
  assign bus.x_funct       = funct_p1;
  assign bus.x_zero        = zero_p1;
  assign bus.x_wb          = wb_p1;
  assign bus.x_m           = m_p1;
  assign bus.x_ex          = ex_p1;

  assign bus.m_alu_result  = alu_result_p2;
  assign bus.m_write_data  = write_data_p2;
  assign bus.m_write_reg   = write_reg_p2;
  assign bus.m_wb          = wb_p2;
  assign bus.m_m           = m_p2;
  assign bus.m_zero        = zero_p2;

endmodule

// File: tb/tb_pipeline_regs.sv
// Directed bench for pipeline_regs: reset, stall, control packing, bubble,
// EX/MEM flow, stage independence.
module tb_pipeline_regs;
  logic clk;
  logic reset;
  int tests_run;
  int tests_failed;

  pipeline_regs_if bus ();

  pipeline_regs dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.ifid_en = 0; bus.f_instruction = 0; bus.f_pc_plus4 = 0;
    bus.idex_en = 0; bus.d_pc_plus4_in = 0; bus.d_sign_ext = 0;
    bus.d_read_data1 = 0; bus.d_read_data2 = 0;
    bus.d_rs = 0; bus.d_rt = 0; bus.d_rd = 0; bus.d_alu_op = 0; bus.d_funct = 0;
    bus.d_reg_write = 0; bus.d_mem_to_reg = 0; bus.d_branch = 0; bus.d_mem_read = 0;
    bus.d_mem_write = 0; bus.d_reg_dst = 0; bus.d_alu_src = 0; bus.d_zero = 0;
    bus.x_alu_result = 0; bus.x_write_data = 0; bus.x_write_reg = 0;
    bus.x_wb_in = 0; bus.x_m_in = 0; bus.x_zero_in = 0;
  endtask

  task automatic set_controls(input logic reg_dst, input logic [1:0] alu_op, input logic alu_src,
                              input logic mem_to_reg, input logic reg_write,
                              input logic branch, input logic mem_read, input logic mem_write);
    bus.d_reg_dst = reg_dst; bus.d_alu_op = alu_op; bus.d_alu_src = alu_src;
    bus.d_mem_to_reg = mem_to_reg; bus.d_reg_write = reg_write;
    bus.d_branch = branch; bus.d_mem_read = mem_read; bus.d_mem_write = mem_write;
  endtask

  task automatic test_reset();
    // fill every stage with nonzero content
    bus.ifid_en = 1; bus.f_instruction = 32'hDEADBEEF; bus.f_pc_plus4 = 32'h00000104;
    bus.idex_en = 1; bus.d_read_data1 = 32'hCAFEF00D; bus.d_rs = 5'd7; bus.d_funct = 6'h2A;
    set_controls(1, 2'b11, 1, 1, 1, 1, 1, 1); bus.d_zero = 1;
    bus.x_alu_result = 32'h00001234; bus.x_write_reg = 5'd9; bus.x_wb_in = 2'b11;
    bus.x_m_in = 3'b111; bus.x_zero_in = 1;
    tick();
    chk("preload_d_instruction", bus.d_instruction, 32'hDEADBEEF);
    chk("preload_x_ex", {28'd0, bus.x_ex}, 32'hF);
    #2;
    reset = 0;
    #1;
    chk("async_reset_ifid", bus.d_instruction | bus.d_pc_plus4, 32'h0);
    chk("async_reset_idex", bus.x_read_data1 | {27'd0, bus.x_rs} | {26'd0, bus.x_funct}
        | {28'd0, bus.x_ex} | {29'd0, bus.x_m} | {30'd0, bus.x_wb} | {31'd0, bus.x_zero}, 32'h0);
    chk("async_reset_exmem", bus.m_alu_result | {27'd0, bus.m_write_reg} | {29'd0, bus.m_m}
        | {30'd0, bus.m_wb} | {31'd0, bus.m_zero}, 32'h0);
    tick();
    tick();
    chk("held_reset_ifid", bus.d_instruction, 32'h0);
    chk("held_reset_exmem", bus.m_alu_result, 32'h0);
    chk("held_reset_idex", {28'd0, bus.x_ex}, 32'h0);
    #2;
    reset = 1;
    bus.f_instruction = 32'h8C220004;
    tick();
    chk("release_d_instruction", bus.d_instruction, 32'h8C220004);
    chk("release_m_alu_result", bus.m_alu_result, 32'h00001234);
  endtask

  task automatic test_stall();
    bus.ifid_en = 1; bus.f_pc_plus4 = 32'h00000008;
    tick();
    chk("stall_load", bus.d_pc_plus4, 32'h00000008);
    bus.ifid_en = 0; bus.f_pc_plus4 = 32'h0000000C; bus.f_instruction = 32'h11111111;
    tick();
    chk("stall_hold_1", bus.d_pc_plus4, 32'h00000008);
    tick();
    chk("stall_hold_2", bus.d_pc_plus4, 32'h00000008);
    chk("stall_hold_instr", bus.d_instruction, 32'h8C220004);
    bus.ifid_en = 1;
    tick();
    chk("stall_resume", bus.d_pc_plus4, 32'h0000000C);
  endtask

  task automatic test_control_packing();
    bus.idex_en = 1; bus.d_zero = 0;
    set_controls(1, 2'b10, 0, 0, 1, 0, 0, 0);
    tick();
    chk("pack_x_ex_r", {28'd0, bus.x_ex}, 32'hC);
    chk("pack_x_wb_r", {30'd0, bus.x_wb}, 32'h1);
    chk("pack_x_m_r", {29'd0, bus.x_m}, 32'h0);
    set_controls(0, 2'b01, 1, 1, 0, 1, 0, 1); bus.d_zero = 1;
    bus.d_pc_plus4_in = 32'h00000040; bus.d_sign_ext = 32'hFFFFFFF0;
    bus.d_read_data2 = 32'h0000BEEF; bus.d_rd = 5'd31; bus.d_funct = 6'h20;
    tick();
    chk("pack_x_ex_alt", {28'd0, bus.x_ex}, 32'h3);
    chk("pack_x_wb_alt", {30'd0, bus.x_wb}, 32'h2);
    chk("pack_x_m_alt", {29'd0, bus.x_m}, 32'h5);
    chk("pack_x_zero", {31'd0, bus.x_zero}, 32'h1);
    chk("data_x_pc_plus4", bus.x_pc_plus4, 32'h00000040);
    chk("data_x_sign_ext", bus.x_sign_ext, 32'hFFFFFFF0);
    chk("data_x_read_data2", bus.x_read_data2, 32'h0000BEEF);
    chk("data_x_rd_funct", {21'd0, bus.x_rd, bus.x_funct}, {21'd0, 5'd31, 6'h20});
  endtask

  task automatic test_bubble();
    set_controls(0, 2'b00, 1, 1, 1, 0, 1, 0); bus.d_zero = 1;
    bus.idex_en = 0; bus.d_rt = 5'd5; bus.d_read_data1 = 32'h00000100;
    tick();
    chk("bubble_x_m", {29'd0, bus.x_m}, 32'h0);
    chk("bubble_x_wb", {30'd0, bus.x_wb}, 32'h0);
    chk("bubble_x_ex", {28'd0, bus.x_ex}, 32'h0);
    chk("bubble_x_zero", {31'd0, bus.x_zero}, 32'h0);
    chk("bubble_x_rt", {27'd0, bus.x_rt}, 32'd5);
    chk("bubble_x_read_data1", bus.x_read_data1, 32'h00000100);
    bus.idex_en = 1;
    tick();
    chk("lw_x_m", {29'd0, bus.x_m}, 32'h2);
    chk("lw_x_wb", {30'd0, bus.x_wb}, 32'h3);
    chk("lw_x_ex", {28'd0, bus.x_ex}, 32'h1);
  endtask

  task automatic test_exmem();
    bus.x_alu_result = 32'h00000010; bus.x_write_reg = 5'd3; bus.x_m_in = 3'b010;
    bus.x_wb_in = 2'b10; bus.x_write_data = 32'h000000AA; bus.x_zero_in = 0;
    tick();
    chk("exmem_alu_result", bus.m_alu_result, 32'h00000010);
    chk("exmem_write_reg", {27'd0, bus.m_write_reg}, 32'd3);
    chk("exmem_m", {29'd0, bus.m_m}, 32'h2);
    chk("exmem_wb", {30'd0, bus.m_wb}, 32'h2);
    chk("exmem_write_data", bus.m_write_data, 32'h000000AA);
    bus.x_alu_result = 32'h80000000; bus.x_write_reg = 5'd17; bus.x_m_in = 3'b001;
    bus.x_wb_in = 2'b01; bus.x_write_data = 32'h12345678; bus.x_zero_in = 1;
    tick();
    chk("exmem_next_alu_result", bus.m_alu_result, 32'h80000000);
    chk("exmem_next_write_reg", {27'd0, bus.m_write_reg}, 32'd17);
    chk("exmem_next_m", {29'd0, bus.m_m}, 32'h1);
    chk("exmem_next_zero", {31'd0, bus.m_zero}, 32'h1);
  endtask

  task automatic test_independence();
    logic [31:0] pc_before;
    bus.ifid_en = 1; bus.f_instruction = 32'h00221820; bus.f_pc_plus4 = 32'h00000020;
    tick();
    pc_before = bus.d_pc_plus4;
    chk("indep_preload", pc_before, 32'h00000020);
    bus.ifid_en = 0; bus.idex_en = 1;
    bus.f_instruction = 32'hFFFFFFFF; bus.f_pc_plus4 = 32'h00000024;
    bus.d_rs = 5'd12; set_controls(1, 2'b10, 0, 0, 1, 0, 0, 0);
    bus.x_alu_result = 32'h0000ABCD;
    tick();
    chk("indep_ifid_hold", bus.d_instruction, 32'h00221820);
    chk("indep_idex_adv", {27'd0, bus.x_rs}, 32'd12);
    chk("indep_idex_ctrl", {28'd0, bus.x_ex}, 32'hC);
    chk("indep_exmem_adv", bus.m_alu_result, 32'h0000ABCD);
    // both stalled and bubbled on the same edge
    bus.idex_en = 0; bus.d_rs = 5'd20; bus.x_alu_result = 32'h00005555;
    tick();
    chk("both_ifid_hold", bus.d_pc_plus4, 32'h00000020);
    chk("both_idex_bubble", {28'd0, bus.x_ex} | {29'd0, bus.x_m} | {30'd0, bus.x_wb}, 32'h0);
    chk("both_idex_data", {27'd0, bus.x_rs}, 32'd20);
    chk("both_exmem_adv", bus.m_alu_result, 32'h00005555);
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    reset = 0;
    clear_inputs();
    tick();
    tick();
    #2;
    reset = 1;
    test_reset();
    test_stall();
    test_control_packing();
    test_bubble();
    test_exmem();
    test_independence();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
